// File: rtl/ysyx_22041071_axi_pkg.sv
// Shared types for the AXI arbiter: FSM encoding, AXI resp codes,
// requester ids.
package ysyx_22041071_axi_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_AR  = 3'd1,
    ST_IF_R   = 3'd2,
    ST_MEM_AR = 3'd3,
    ST_MEM_R  = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_MEM_B  = 3'd6
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/ysyx_22041071_arb_grant.sv
// Grant select between IF and MEM requesters.
// Ports: clk, reset_n, if_valid, mem_valid, idle -> gnt_if, gnt_mem.
// Macro YSYX_22041071_ARB_RR_EN: round-robin on ties, else MEM > IF.
module ysyx_22041071_arb_grant
  import ysyx_22041071_axi_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic if_valid,
  input  logic mem_valid,
  input  logic idle,
  output logic gnt_if,
  output logic gnt_mem
);

`ifdef YSYX_22041071_ARB_RR_EN
  logic last_grant;
  logic tie;

  assign tie = if_valid & mem_valid;

  always_comb begin
    gnt_if  = 1'b0;
    gnt_mem = 1'b0;
    if (tie) begin
      // the side that did not win last time wins the tie
      gnt_mem = (last_grant == REQ_IF);
      gnt_if  = (last_grant == REQ_MEM);
    end else begin
      gnt_if  = if_valid;
      gnt_mem = mem_valid;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= REQ_IF;
    end else if (idle & (gnt_if | gnt_mem)) begin
      last_grant <= gnt_mem ? REQ_MEM : REQ_IF;
    end
  end
`else
  logic unused_rr;

  assign gnt_mem   = mem_valid;
  assign gnt_if    = if_valid & ~mem_valid;
  assign unused_rr = ^{clk, reset_n, idle};
`endif

endmodule

// File: rtl/ysyx_22041071_axi_arbiter.sv
// Shares one AXI master between IF fetch and MEM load/store; one
// transaction in flight. Ports: if_req/rsp, mem_req/rsp, AXI AR/R/AW/W/B.
// Macro YSYX_22041071_ARB_RR_EN selects round-robin grant.
module ysyx_22041071_axi_arbiter
  import ysyx_22041071_axi_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int RESP_W = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_data,
  output logic [RESP_W-1:0]   if_rsp_resp,
  input  logic                mem_req_valid,
  output logic                mem_req_ready,
  input  logic                mem_req_we,
  input  logic [ADDR_W-1:0]   mem_req_addr,
  input  logic [DATA_W-1:0]   mem_req_wdata,
  input  logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic                mem_rsp_valid,
  output logic [DATA_W-1:0]   mem_rsp_data,
  output logic [RESP_W-1:0]   mem_rsp_resp,
  output logic                axi_ar_valid,
  output logic [ADDR_W-1:0]   axi_ar_addr,
  input  logic                axi_ar_ready,
  input  logic                axi_r_valid,
  input  logic [DATA_W-1:0]   axi_r_data,
  input  logic [RESP_W-1:0]   axi_r_resp,
  output logic                axi_r_ready,
  output logic                axi_aw_valid,
  output logic [ADDR_W-1:0]   axi_aw_addr,
  input  logic                axi_aw_ready,
  output logic                axi_w_valid,
  output logic [DATA_W-1:0]   axi_w_data,
  output logic [DATA_W/8-1:0] axi_w_strb,
  input  logic                axi_w_ready,
  input  logic                axi_b_valid,
  input  logic [RESP_W-1:0]   axi_b_resp,
  output logic                axi_b_ready
);

  arb_state_e state_q;
  arb_state_e state_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                aw_done;
  logic                w_done;

  logic idle;
  logic gnt_if;
  logic gnt_mem;
  logic if_fire;
  logic mem_fire;
  logic aw_ok;
  logic w_ok;
  logic if_r_hs;
  logic mem_r_hs;
  logic mem_b_hs;

  assign idle = (state_q == ST_IDLE);

  ysyx_22041071_arb_grant u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .if_valid  (if_req_valid),
    .mem_valid (mem_req_valid),
    .idle      (idle),
    .gnt_if    (gnt_if),
    .gnt_mem   (gnt_mem)
  );

  // readies are forced low while reset is asserted
  assign if_req_ready  = reset_n & idle & gnt_if;
  assign mem_req_ready = reset_n & idle & gnt_mem;
  assign if_fire       = if_req_valid & if_req_ready;
  assign mem_fire      = mem_req_valid & mem_req_ready;

  assign axi_ar_valid = (state_q == ST_IF_AR) | (state_q == ST_MEM_AR);
  assign axi_ar_addr  = addr_q;
  assign axi_r_ready  = (state_q == ST_IF_R) | (state_q == ST_MEM_R);
  assign axi_aw_valid = (state_q == ST_MEM_WR) & ~aw_done;
  assign axi_aw_addr  = addr_q;
  assign axi_w_valid  = (state_q == ST_MEM_WR) & ~w_done;
  assign axi_w_data   = wdata_q;
  assign axi_w_strb   = wstrb_q;
  assign axi_b_ready  = (state_q == ST_MEM_B);

  // a channel counts as done once its beat was taken, now or earlier
  assign aw_ok = aw_done | (axi_aw_valid & axi_aw_ready);
  assign w_ok  = w_done | (axi_w_valid & axi_w_ready);

  assign if_r_hs  = (state_q == ST_IF_R) & axi_r_valid;
  assign mem_r_hs = (state_q == ST_MEM_R) & axi_r_valid;
  assign mem_b_hs = (state_q == ST_MEM_B) & axi_b_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_fire) begin
          state_d = mem_req_we ? ST_MEM_WR : ST_MEM_AR;
        end else if (if_fire) begin
          state_d = ST_IF_AR;
        end
      end
      ST_IF_AR:  if (axi_ar_ready) state_d = ST_IF_R;
      ST_IF_R:   if (axi_r_valid) state_d = ST_IDLE;
      ST_MEM_AR: if (axi_ar_ready) state_d = ST_MEM_R;
      ST_MEM_R:  if (axi_r_valid) state_d = ST_IDLE;
      ST_MEM_WR: if (aw_ok & w_ok) state_d = ST_MEM_B;
      ST_MEM_B:  if (axi_b_valid) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // done flags live only while the write stays in MEM_WR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= (state_d == ST_MEM_WR) & (state_q == ST_MEM_WR) & aw_ok;
      w_done  <= (state_d == ST_MEM_WR) & (state_q == ST_MEM_WR) & w_ok;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (mem_fire) begin
      addr_q  <= mem_req_addr;
      wdata_q <= mem_req_wdata;
      wstrb_q <= mem_req_wstrb;
    end else if (if_fire) begin
      addr_q  <= if_req_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      if_rsp_resp  <= '0;
    end else begin
      if_rsp_valid <= if_r_hs;
      if (if_r_hs) begin
        if_rsp_data <= axi_r_data;
        if_rsp_resp <= axi_r_resp;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
      mem_rsp_resp  <= '0;
    end else begin
      mem_rsp_valid <= mem_r_hs | mem_b_hs;
      if (mem_r_hs) begin
        mem_rsp_data <= axi_r_data;
        mem_rsp_resp <= axi_r_resp;
      end else if (mem_b_hs) begin
        mem_rsp_data <= '0;
        mem_rsp_resp <= axi_b_resp;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_axi_arbiter.sv
// Scoreboard bench for ysyx_22041071_axi_arbiter: directed requests,
// a delay-configurable AXI slave, and a negedge monitor.
module tb_ysyx_22041071_axi_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        if_req_valid, if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic [63:0] if_rsp_data;
  logic [1:0]  if_rsp_resp;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic [1:0]  mem_rsp_resp;
  logic        axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_ar_addr;
  logic        axi_r_valid, axi_r_ready;
  logic [63:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_aw_valid, axi_aw_ready;
  logic [63:0] axi_aw_addr;
  logic        axi_w_valid, axi_w_ready;
  logic [63:0] axi_w_data;
  logic [7:0]  axi_w_strb;
  logic        axi_b_valid, axi_b_ready;
  logic [1:0]  axi_b_resp;

  ysyx_22041071_axi_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
    .if_req_addr(if_req_addr), .if_rsp_valid(if_rsp_valid),
    .if_rsp_data(if_rsp_data), .if_rsp_resp(if_rsp_resp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_resp(mem_rsp_resp),
    .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_valid(axi_r_valid), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_ready(axi_r_ready),
    .axi_aw_valid(axi_aw_valid), .axi_aw_addr(axi_aw_addr),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_valid(axi_w_valid), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_ready(axi_w_ready),
    .axi_b_valid(axi_b_valid), .axi_b_resp(axi_b_resp),
    .axi_b_ready(axi_b_ready)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  logic [63:0] exp_ar_q[$];
  logic [63:0] exp_aw_q[$];
  logic [71:0] exp_w_q[$];
  logic [65:0] exp_if_q[$];
  logic [65:0] exp_mem_q[$];
  logic [65:0] slv_rd_q[$];

  int ar_dly = 0, aw_dly = 0, w_dly = 0;
  int r_lat = 1, b_lat = 1;
  logic [1:0] b_resp_cfg = 2'b00;
  int flush_req = 0;
  int flush_ack = 0;

  int aw_vcnt = 0, w_vcnt = 0, b_rcnt = 0;
  int mem_pulses = 0, rr_cnt = 0;
  longint burst_c[4];

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic unexp(input string nm, input logic [127:0] got);
    checks++;
    errors++;
    $display("FAIL %s got %0h want none", nm, got);
  endtask

  function automatic logic [511:0] all_outs();
    return {if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_resp,
            mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_resp,
            axi_ar_valid, axi_ar_addr, axi_r_ready, axi_aw_valid,
            axi_aw_addr, axi_w_valid, axi_w_data, axi_w_strb,
            axi_b_ready};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // AXI slave: readies after a per-channel wait, R/B after a latency
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit r_pend, aw_got, w_got, b_pend;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    logic [65:0] cur;
    r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    cur = '0;
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0;
    forever begin
      @(negedge clk);
      ar_hs = axi_ar_valid & axi_ar_ready;
      r_hs  = axi_r_valid & axi_r_ready;
      aw_hs = axi_aw_valid & axi_aw_ready;
      w_hs  = axi_w_valid & axi_w_ready;
      b_hs  = axi_b_valid & axi_b_ready;
      if (axi_ar_valid && !axi_ar_ready) ar_cnt++;
      if (axi_aw_valid && !axi_aw_ready) aw_cnt++;
      if (axi_w_valid && !axi_w_ready) w_cnt++;
      @(posedge clk);
      #1;
      if (flush_req != flush_ack) begin
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        axi_r_valid = 0; axi_b_valid = 0;
        flush_ack = flush_req;
      end else begin
        if (r_hs) begin axi_r_valid = 0; r_pend = 0; end
        if (ar_hs) begin
          ar_cnt = 0;
          r_pend = 1;
          r_cnt = r_lat;
          cur = (slv_rd_q.size() > 0) ? slv_rd_q.pop_front() : '0;
        end
        if (r_pend && !axi_r_valid) begin
          r_cnt--;
          if (r_cnt <= 0) begin
            axi_r_valid = 1;
            axi_r_data  = cur[65:2];
            axi_r_resp  = cur[1:0];
          end
        end
        if (b_hs) begin axi_b_valid = 0; b_pend = 0; end
        if (aw_hs) begin aw_got = 1; aw_cnt = 0; end
        if (w_hs) begin w_got = 1; w_cnt = 0; end
        if (aw_got && w_got && !b_pend) begin
          b_pend = 1; b_cnt = b_lat; aw_got = 0; w_got = 0;
        end
        if (b_pend && !axi_b_valid) begin
          b_cnt--;
          if (b_cnt <= 0) begin
            axi_b_valid = 1;
            axi_b_resp  = b_resp_cfg;
          end
        end
      end
      axi_ar_ready = axi_ar_valid && (ar_cnt >= ar_dly);
      axi_aw_ready = axi_aw_valid && (aw_cnt >= aw_dly);
      axi_w_ready  = axi_w_valid && (w_cnt >= w_dly);
    end
  end

  // monitor: pops the scoreboard whenever the DUT presents a beat
  initial forever begin
    @(negedge clk);
    aw_vcnt    += int'(axi_aw_valid);
    w_vcnt     += int'(axi_w_valid);
    b_rcnt     += int'(axi_b_ready);
    mem_pulses += int'(mem_rsp_valid);
    rr_cnt     += int'(axi_r_ready);
    if (reset_n) begin
      if (axi_ar_valid && axi_ar_ready) begin
        if (exp_ar_q.size() == 0) unexp("ar_addr", axi_ar_addr);
        else chk("ar_addr", axi_ar_addr, exp_ar_q.pop_front());
      end
      if (axi_aw_valid && axi_aw_ready) begin
        if (exp_aw_q.size() == 0) unexp("aw_addr", axi_aw_addr);
        else chk("aw_addr", axi_aw_addr, exp_aw_q.pop_front());
      end
      if (axi_w_valid && axi_w_ready) begin
        if (exp_w_q.size() == 0) unexp("w_beat", {axi_w_data, axi_w_strb});
        else chk("w_beat", {axi_w_data, axi_w_strb}, exp_w_q.pop_front());
      end
      if (if_rsp_valid) begin
        if (exp_if_q.size() == 0) unexp("if_rsp", {if_rsp_data, if_rsp_resp});
        else chk("if_rsp", {if_rsp_data, if_rsp_resp}, exp_if_q.pop_front());
      end
      if (mem_rsp_valid) begin
        if (exp_mem_q.size() == 0)
          unexp("mem_rsp", {mem_rsp_data, mem_rsp_resp});
        else
          chk("mem_rsp", {mem_rsp_data, mem_rsp_resp}, exp_mem_q.pop_front());
      end
      if (if_req_valid && mem_req_valid)
        chk("both_ready", if_req_ready & mem_req_ready, 0);
    end
  end

  task automatic if_req(input logic [63:0] a, output longint c);
    int n = 0;
    c = 0;
    @(posedge clk); #1;
    if_req_valid = 1;
    if_req_addr  = a;
    while (n < 200) begin
      @(negedge clk);
      if (if_req_ready) break;
      n++;
    end
    c = cyc;
    chk("if_req_timeout", n >= 200, 0);
    @(posedge clk); #1;
    if_req_valid = 0;
  endtask

  task automatic mem_req(input logic we, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] s,
                         output longint c);
    int n = 0;
    c = 0;
    @(posedge clk); #1;
    mem_req_valid = 1;
    mem_req_we    = we;
    mem_req_addr  = a;
    mem_req_wdata = d;
    mem_req_wstrb = s;
    while (n < 200) begin
      @(negedge clk);
      if (mem_req_ready) break;
      n++;
    end
    c = cyc;
    chk("mem_req_timeout", n >= 200, 0);
    @(posedge clk); #1;
    mem_req_valid = 0;
  endtask

  task automatic if_burst(input int cnt, input logic [63:0] base);
    int k = 0;
    int t = 0;
    @(posedge clk); #1;
    if_req_valid = 1;
    if_req_addr  = base;
    while (k < cnt && t < 400) begin
      @(negedge clk);
      t++;
      if (if_req_ready) begin
        burst_c[k] = cyc;
        k++;
      end
      @(posedge clk); #1;
      if_req_addr = base + 64'(4 * k);
    end
    if_req_valid = 0;
    chk("burst_timeout", k, cnt);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() +
            exp_if_q.size() + exp_mem_q.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n >= 300, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    longint ci, cm;
    int mark_a, mark_w, mark_b, mark_m, mark_r, n;
    if_req_valid = 0; if_req_addr = 0;
    mem_req_valid = 0; mem_req_we = 0; mem_req_addr = 0;
    mem_req_wdata = 0; mem_req_wstrb = 0;

    #12;
    chk("reset_outs", all_outs(), '0);
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    chk("idle_outs", all_outs(), '0);

    // 1: single fetch, R two cycles after AR
    r_lat = 2;
    slv_rd_q.push_back({64'h0000_0013_0000_0013, 2'b00});
    exp_ar_q.push_back(64'h8000_0000);
    exp_if_q.push_back({64'h0000_0013_0000_0013, 2'b00});
    if_req(64'h8000_0000, ci);
    drain("t1_drain");

    // 3: store, AW ready in cycle 1, W ready in cycle 3
    r_lat = 1; aw_dly = 0; w_dly = 2; b_lat = 1; b_resp_cfg = 2'b00;
    mark_a = aw_vcnt; mark_w = w_vcnt; mark_b = b_rcnt;
    exp_aw_q.push_back(64'h8000_1000);
    exp_w_q.push_back({64'h0000_0000_DEAD_BEEF, 8'hFF});
    exp_mem_q.push_back({64'h0, 2'b00});
    mem_req(1, 64'h8000_1000, 64'h0000_0000_DEAD_BEEF, 8'hFF, cm);
    drain("t3_drain");
    chk("t3_aw_cycles", aw_vcnt - mark_a, 1);
    chk("t3_w_cycles", w_vcnt - mark_w, 3);
    chk("t3_b_cycles", b_rcnt - mark_b, 1);

    // store with AW late, W early, DECERR passed through
    aw_dly = 2; w_dly = 0; b_resp_cfg = 2'b11;
    mark_a = aw_vcnt; mark_w = w_vcnt;
    exp_aw_q.push_back(64'h8000_1008);
    exp_w_q.push_back({64'h0123_4567_89AB_CDEF, 8'h0F});
    exp_mem_q.push_back({64'h0, 2'b11});
    mem_req(1, 64'h8000_1008, 64'h0123_4567_89AB_CDEF, 8'h0F, cm);
    drain("t7_drain");
    chk("t7_aw_cycles", aw_vcnt - mark_a, 3);
    chk("t7_w_cycles", w_vcnt - mark_w, 1);
    aw_dly = 0; b_resp_cfg = 2'b00;

    // 4: load returning SLVERR
    mark_m = mem_pulses;
    slv_rd_q.push_back({64'h1122_3344_5566_7788, 2'b10});
    exp_ar_q.push_back(64'h8000_2000);
    exp_mem_q.push_back({64'h1122_3344_5566_7788, 2'b10});
    mem_req(0, 64'h8000_2000, 64'h0, 8'h0, cm);
    drain("t4_drain");
    chk("t4_pulses", mem_pulses - mark_m, 1);
    chk("t4_idle", {axi_ar_valid, axi_r_ready, axi_aw_valid,
                    axi_w_valid, axi_b_ready}, 0);

    // 2: IF and MEM reads in the same cycle
`ifdef YSYX_22041071_ARB_RR_EN
    slv_rd_q.push_back({64'h0000_0000_0010_0093, 2'b00});
    slv_rd_q.push_back({64'hCAFE_F00D_1234_5678, 2'b00});
    exp_ar_q.push_back(64'h8000_0008);
    exp_ar_q.push_back(64'h8000_3000);
`else
    slv_rd_q.push_back({64'hCAFE_F00D_1234_5678, 2'b00});
    slv_rd_q.push_back({64'h0000_0000_0010_0093, 2'b00});
    exp_ar_q.push_back(64'h8000_3000);
    exp_ar_q.push_back(64'h8000_0008);
`endif
    exp_if_q.push_back({64'h0000_0000_0010_0093, 2'b00});
    exp_mem_q.push_back({64'hCAFE_F00D_1234_5678, 2'b00});
    fork
      if_req(64'h8000_0008, ci);
      mem_req(0, 64'h8000_3000, 64'h0, 8'h0, cm);
    join
    drain("t2_drain");
`ifdef YSYX_22041071_ARB_RR_EN
    chk("t2_order", cm - ci, 3);
`else
    chk("t2_order", ci - cm, 3);
`endif

    // 5: reset in the middle of MEM_R
    r_lat = 8;
    slv_rd_q.push_back({64'h5555_AAAA_5555_AAAA, 2'b00});
    exp_ar_q.push_back(64'h8000_4000);
    mem_req(0, 64'h8000_4000, 64'h0, 8'h0, cm);
    n = 0;
    while (!axi_r_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_mem_r", axi_r_ready, 1);
    #2;
    reset_n = 0;
    #1;
    chk("t5_reset_outs", all_outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    mark_m = mem_pulses;
    mark_r = rr_cnt;
    repeat (12) @(negedge clk);
    chk("t5_stray_r_seen", axi_r_valid, 1);
    chk("t5_no_rsp", mem_pulses - mark_m, 0);
    chk("t5_no_r_ready", rr_cnt - mark_r, 0);
    flush_req++;
    n = 0;
    while (flush_ack != flush_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    r_lat = 1;

    // 6: back-to-back fetches, one every three cycles
    for (int k = 0; k < 4; k++) begin
      slv_rd_q.push_back({64'h0000_0100_0000_0000 + 64'(k), 2'b00});
      exp_ar_q.push_back(64'h8000_0100 + 64'(4 * k));
      exp_if_q.push_back({64'h0000_0100_0000_0000 + 64'(k), 2'b00});
    end
    if_burst(4, 64'h8000_0100);
    drain("t6_drain");
    for (int k = 1; k < 4; k++)
      chk("t6_spacing", burst_c[k] - burst_c[k-1], 3);

    chk("final_slv_q", slv_rd_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
